// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the Wishbone-attached UART.
//   - register address constants (DATA, STATUS, DIV_LO, DIV_HI)
//   - STATUS bit index constants
//   - uart_state_t: state encoding used by both the TX and RX FSMs
//   - eff_div(): clamps a programmed divisor to the minimum usable value
package uart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DIV_LO = 2'd2;
    localparam logic [1:0] ADDR_DIV_HI = 2'd3;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_OVERRUN  = 4;
    localparam int ST_FRAMING  = 5;
    localparam int ST_TX_BUSY  = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    localparam logic [15:0] DIV_MIN = 16'd4;

    // Divisors below DIV_MIN leave no room for a mid-bit sample point.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers.
// Parameters: WIDTH (data bits), DEPTH (entries, power of two).
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_push, i_push_data   write request and data (dropped when full unless
//                         a pop happens in the same cycle)
//   i_pop                 read request (ignored when empty)
//   o_pop_data            head entry, valid whenever o_empty=0
//   o_full, o_empty       exact occupancy flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    // Same slot index but different wrap bit: writer is one lap ahead.
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the head slot, so a push into a full
    // FIFO is still accepted; the head is read before it is overwritten.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign o_pop_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/uart_wb_fifo.sv
// uart_wb_fifo: 8N1 UART with TX/RX FIFOs behind a small Wishbone-style
// register port.
// Parameters: CLK_HZ (clock Hz), BAUD (reset baud), FIFO_DEPTH (entries).
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   wb_addr, wb_data_in, wb_we   register select, write data, direction
//   wb_stb / wb_ack              request / one-cycle acknowledge
//   wb_data_out                  read data, valid while wb_ack=1
//   tx_bit / rx_bit              serial lines (rx_bit is asynchronous)
//   irq                          interrupt request
// Build option: define UART_WB_FIFO_IRQ_EN to enable the registered irq
// output; otherwise irq is tied low.
//
// Handshake: a request is accepted on a rising edge where wb_stb=1 and
// wb_ack=0; wb_ack is high for the following cycle only, and the side
// effect (push, pop, register write) happens exactly at the accepting
// edge. Holding wb_stb high therefore yields an ack every other cycle.
module uart_wb_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] wb_addr,
    input  logic [7:0] wb_data_in,
    output logic [7:0] wb_data_out,
    input  logic       wb_we,
    input  logic       wb_stb,
    output logic       wb_ack,
    output logic       tx_bit,
    input  logic       rx_bit,
    output logic       irq
);

    localparam logic [15:0] DIV_RESET = 16'(CLK_HZ / BAUD);

    // ---------------- bus side ----------------
    logic        r_ack;
    logic [7:0]  r_rdata;
    logic [15:0] r_div;
    logic        r_overrun;
    logic        r_framing;
    logic        w_acc, w_wr, w_rd, w_sts_wr;
    logic        w_tx_push, w_rx_pop;
    logic [7:0]  w_status;
    logic [7:0]  w_rdata;

    logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [7:0]  w_tx_dout, w_rx_dout;

    assign w_acc     = wb_stb && !r_ack;
    assign w_wr      = w_acc && wb_we;
    assign w_rd      = w_acc && !wb_we;
    assign w_sts_wr  = w_wr && (wb_addr == ADDR_STATUS);
    assign w_tx_push = w_wr && (wb_addr == ADDR_DATA);
    assign w_rx_pop  = w_rd && (wb_addr == ADDR_DATA);

    // ---------------- TX FSM signals ----------------
    uart_state_t r_tx_state, w_tx_next;
    logic [15:0] r_tx_div, r_tx_cnt;
    logic [2:0]  r_tx_idx;
    logic [7:0]  r_tx_shift;
    logic        w_tx_bit_end, w_tx_pop, w_tx_line;

    // ---------------- RX FSM signals ----------------
    uart_state_t r_rx_state, w_rx_next;
    logic [1:0]  r_rx_sync;
    logic [15:0] r_rx_div, r_rx_cnt;
    logic [2:0]  r_rx_idx;
    logic [7:0]  r_rx_shift;
    logic        w_rx_line, w_rx_half, w_rx_bit_end;
    logic        w_rx_push, w_rx_ovr, w_rx_frm;

    always_comb begin
        w_status              = 8'h00;
        w_status[ST_TX_FULL]  = w_tx_full;
        w_status[ST_TX_EMPTY] = w_tx_empty;
        w_status[ST_RX_EMPTY] = w_rx_empty;
        w_status[ST_RX_FULL]  = w_rx_full;
        w_status[ST_OVERRUN]  = r_overrun;
        w_status[ST_FRAMING]  = r_framing;
        w_status[ST_TX_BUSY]  = (r_tx_state != S_IDLE);
    end

    always_comb begin
        w_rdata = 8'h00;
        case (wb_addr)
            ADDR_DATA:   w_rdata = w_rx_empty ? 8'h00 : w_rx_dout;
            ADDR_STATUS: w_rdata = w_status;
            ADDR_DIV_LO: w_rdata = r_div[7:0];
            ADDR_DIV_HI: w_rdata = r_div[15:8];
            default:     w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ack     <= 1'b0;
            r_rdata   <= 8'h00;
            r_div     <= DIV_RESET;
            r_overrun <= 1'b0;
            r_framing <= 1'b0;
        end else begin
            r_ack   <= w_acc;
            r_rdata <= w_rd ? w_rdata : 8'h00;
            if (w_wr && wb_addr == ADDR_DIV_LO) r_div[7:0]  <= wb_data_in;
            if (w_wr && wb_addr == ADDR_DIV_HI) r_div[15:8] <= wb_data_in;
            // A new error event in the clearing cycle wins over the clear.
            r_overrun <= (r_overrun && !(w_sts_wr && wb_data_in[ST_OVERRUN])) || w_rx_ovr;
            r_framing <= (r_framing && !(w_sts_wr && wb_data_in[ST_FRAMING])) || w_rx_frm;
        end
    end

    assign wb_ack      = r_ack;
    assign wb_data_out = r_rdata;

    // ---------------- FIFOs ----------------
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk       (clk),
        .i_rst_n     (reset_n),
        .i_push      (w_tx_push),
        .i_push_data (wb_data_in),
        .i_pop       (w_tx_pop),
        .o_pop_data  (w_tx_dout),
        .o_full      (w_tx_full),
        .o_empty     (w_tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk       (clk),
        .i_rst_n     (reset_n),
        .i_push      (w_rx_push),
        .i_push_data (r_rx_shift),
        .i_pop       (w_rx_pop),
        .o_pop_data  (w_rx_dout),
        .o_full      (w_rx_full),
        .o_empty     (w_rx_empty)
    );

    // ---------------- TX FSM ----------------
    assign w_tx_bit_end = (r_tx_cnt == r_tx_div - 16'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_tx_state <= S_IDLE;
        else          r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            S_IDLE:  if (!w_tx_empty) w_tx_next = S_START;
            S_START: if (w_tx_bit_end) w_tx_next = S_DATA;
            S_DATA:  if (w_tx_bit_end && r_tx_idx == 3'd7) w_tx_next = S_STOP;
            S_STOP:  if (w_tx_bit_end) w_tx_next = w_tx_empty ? S_IDLE : S_START;
            default: w_tx_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_tx_line = 1'b1;
        w_tx_pop  = 1'b0;
        case (r_tx_state)
            S_IDLE:  w_tx_pop  = !w_tx_empty;
            S_START: w_tx_line = 1'b0;
            S_DATA:  w_tx_line = r_tx_shift[0];
            // Popping at the end of the stop bit chains frames with no gap.
            S_STOP:  w_tx_pop  = w_tx_bit_end && !w_tx_empty;
            default: w_tx_line = 1'b1;
        endcase
    end

    // The line is decoded from state, so reset forces it high immediately.
    assign tx_bit = w_tx_line;

    // The divisor is latched with each popped byte, so reprogramming it
    // mid-frame only affects the next frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_div   <= eff_div(DIV_RESET);
            r_tx_cnt   <= 16'd0;
            r_tx_idx   <= 3'd0;
            r_tx_shift <= 8'h00;
        end else if (w_tx_pop) begin
            r_tx_div   <= eff_div(r_div);
            r_tx_cnt   <= 16'd0;
            r_tx_idx   <= 3'd0;
            r_tx_shift <= w_tx_dout;
        end else if (r_tx_state != S_IDLE) begin
            if (w_tx_bit_end) begin
                r_tx_cnt <= 16'd0;
                if (r_tx_state == S_DATA) begin
                    r_tx_shift <= r_tx_shift >> 1;
                    r_tx_idx   <= r_tx_idx + 3'd1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + 16'd1;
            end
        end
    end

    // ---------------- RX FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rx_sync <= 2'b11;
        else          r_rx_sync <= {r_rx_sync[0], rx_bit};
    end

    assign w_rx_line    = r_rx_sync[1];
    assign w_rx_half    = (r_rx_cnt == (r_rx_div >> 1));
    assign w_rx_bit_end = (r_rx_cnt == r_rx_div - 16'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rx_state <= S_IDLE;
        else          r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            S_IDLE:  if (!w_rx_line) w_rx_next = S_START;
            // A line back high at mid start bit was a glitch.
            S_START: if (w_rx_half) w_rx_next = w_rx_line ? S_IDLE : S_DATA;
            S_DATA:  if (w_rx_bit_end && r_rx_idx == 3'd7) w_rx_next = S_STOP;
            S_STOP:  if (w_rx_bit_end) w_rx_next = S_IDLE;
            default: w_rx_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rx_push = 1'b0;
        w_rx_ovr  = 1'b0;
        w_rx_frm  = 1'b0;
        if (r_rx_state == S_STOP && w_rx_bit_end) begin
            w_rx_push = w_rx_line;
            // Full with a same-cycle bus pop still has room for the byte.
            w_rx_ovr  = w_rx_line && w_rx_full && !w_rx_pop;
            w_rx_frm  = !w_rx_line;
        end
    end

    // After the mid-start resample every later sample is one full bit on,
    // which lands each data and stop sample at mid-bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_div   <= eff_div(DIV_RESET);
            r_rx_cnt   <= 16'd0;
            r_rx_idx   <= 3'd0;
            r_rx_shift <= 8'h00;
        end else begin
            case (r_rx_state)
                S_IDLE: begin
                    r_rx_cnt <= 16'd0;
                    r_rx_idx <= 3'd0;
                    r_rx_div <= eff_div(r_div);
                end
                S_START: r_rx_cnt <= w_rx_half ? 16'd0 : r_rx_cnt + 16'd1;
                S_DATA: begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt   <= 16'd0;
                        r_rx_shift <= {w_rx_line, r_rx_shift[7:1]};
                        r_rx_idx   <= r_rx_idx + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                S_STOP:  r_rx_cnt <= w_rx_bit_end ? 16'd0 : r_rx_cnt + 16'd1;
                default: r_rx_cnt <= 16'd0;
            endcase
        end
    end

    // ---------------- interrupt ----------------
`ifdef UART_WB_FIFO_IRQ_EN
    logic r_irq;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_irq <= 1'b0;
        else          r_irq <= !w_rx_empty || w_tx_empty || r_overrun || r_framing;
    end
    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_wb_fifo.sv
// tb_uart_wb_fifo: directed bench for uart_wb_fifo (default build, irq off).
// Covers reset state, register access, TX waveforms (including back-to-back,
// divisor hold and clamp), RX receive, empty read, glitch rejection,
// framing, overrun and reset mid-frame.
module tb_uart_wb_fifo;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_DIV_LO = 2'd2;
    localparam logic [1:0] A_DIV_HI = 2'd3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] wb_addr;
    logic [7:0] wb_data_in;
    logic [7:0] wb_data_out;
    logic       wb_we;
    logic       wb_stb;
    logic       wb_ack;
    logic       tx_bit;
    logic       rx_bit;
    logic       irq;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    uart_wb_fifo #(
        .CLK_HZ     (12000000),
        .BAUD       (115200),
        .FIFO_DEPTH (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wb_addr     (wb_addr),
        .wb_data_in  (wb_data_in),
        .wb_data_out (wb_data_out),
        .wb_we       (wb_we),
        .wb_stb      (wb_stb),
        .wb_ack      (wb_ack),
        .tx_bit      (tx_bit),
        .rx_bit      (rx_bit),
        .irq         (irq)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- bus drivers ----------------
    task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
        int lat = 0;
        @(negedge clk);
        wb_addr = a; wb_data_in = d; wb_we = 1'b1; wb_stb = 1'b1;
        do begin
            @(posedge clk); #1; lat++;
        end while (!wb_ack && lat < 8);
        check_eq("wr_ack_lat", lat, 1);
        @(negedge clk);
        wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [7:0] d);
        int lat = 0;
        @(negedge clk);
        wb_addr = a; wb_we = 1'b0; wb_stb = 1'b1;
        do begin
            @(posedge clk); #1; lat++;
        end while (!wb_ack && lat < 8);
        check_eq("rd_ack_lat", lat, 1);
        d = wb_data_out;
        @(negedge clk);
        wb_stb = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        wb_read(a, d);
        check_eq(tag, d, exp);
    endtask

    // ---------------- serial drivers ----------------
    task automatic uart_send(input logic [7:0] b, input logic stop_v);
        @(negedge clk);
        rx_bit = 1'b0;
        repeat (104) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_bit = b[i];
            repeat (104) @(negedge clk);
        end
        rx_bit = stop_v;
        repeat (104) @(negedge clk);
        rx_bit = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    // Waits for a start bit, then compares tx_bit on every cycle of nfr
    // frames (bytes b0, b1) plus one idle bit time against the ideal wave.
    task automatic tx_expect(input logic [7:0] b0, input logic [7:0] b1,
                             input int nfr, input int div, input string tag);
        int waited = 0;
        int errs   = 0;
        int total;
        while (tx_bit !== 1'b0 && waited < 200) begin
            @(negedge clk); waited++;
        end
        check_eq({tag, "_start"}, (tx_bit === 1'b0), 1);
        total = nfr * 10 * div + div;
        for (int n = 0; n < total; n++) begin
            logic       e;
            int         f, k;
            logic [7:0] b;
            f = n / (10 * div);
            k = (n % (10 * div)) / div;
            b = (f == 0) ? b0 : b1;
            if (f >= nfr)    e = 1'b1;
            else if (k == 0) e = 1'b0;
            else if (k == 9) e = 1'b1;
            else             e = b[k-1];
            if (tx_bit !== e) errs++;
            @(negedge clk);
        end
        check_eq({tag, "_wave_errs"}, errs, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] pat;

        reset_n = 1'b0; rx_bit = 1'b1;
        wb_addr = 2'd0; wb_data_in = 8'h00; wb_we = 1'b0; wb_stb = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx_bit", tx_bit, 1);
        check_eq("rst_ack", wb_ack, 0);
        check_eq("rst_dout", wb_data_out, 8'h00);
        check_eq("rst_irq", irq, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        rd_check("rst_status", A_STATUS, 8'h06);
        rd_check("rst_div_lo", A_DIV_LO, 8'h68);
        rd_check("rst_div_hi", A_DIV_HI, 8'h00);

        // stb held high: ack on alternate cycles
        @(negedge clk);
        wb_addr = A_STATUS; wb_we = 1'b0; wb_stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1; pat[i] = wb_ack;
        end
        @(negedge clk);
        wb_stb = 1'b0;
        check_eq("ack_alternate", pat, 4'b0101);

        // TX 0xA5 at divisor 104
        wb_write(A_DATA, 8'hA5);
        tx_expect(8'hA5, 8'h00, 1, 104, "tx_a5");
        rd_check("tx_done_status", A_STATUS, 8'h06);

        // back-to-back frames at divisor 16
        wb_write(A_DIV_LO, 8'd16);
        fork
            tx_expect(8'h01, 8'h80, 2, 16, "tx_b2b");
            begin
                wb_write(A_DATA, 8'h01);
                wb_write(A_DATA, 8'h80);
            end
        join

        // divisor change mid-frame keeps the frame at its old divisor
        fork
            tx_expect(8'h96, 8'h00, 1, 16, "tx_divhold");
            begin
                wb_write(A_DATA, 8'h96);
                repeat (40) @(negedge clk);
                wb_write(A_DIV_LO, 8'd8);
            end
        join
        wb_write(A_DATA, 8'h3C);
        tx_expect(8'h3C, 8'h00, 1, 8, "tx_div8");

        // divisor below 4 is treated as 4, register keeps the raw value
        wb_write(A_DIV_LO, 8'd1);
        rd_check("div_lo_raw", A_DIV_LO, 8'h01);
        wb_write(A_DATA, 8'hC3);
        tx_expect(8'hC3, 8'h00, 1, 4, "tx_clamp");

        wb_write(A_DIV_HI, 8'h01);
        rd_check("div_hi_rw", A_DIV_HI, 8'h01);
        wb_write(A_DIV_HI, 8'h00);
        wb_write(A_DIV_LO, 8'h68);

        // RX 0x3C
        uart_send(8'h3C, 1'b1);
        rd_check("rx_status", A_STATUS, 8'h02);
        rd_check("rx_data", A_DATA, 8'h3C);
        rd_check("rx_status_after", A_STATUS, 8'h06);
        rd_check("rx_empty_read", A_DATA, 8'h00);
        rd_check("rx_empty_ptrs", A_STATUS, 8'h06);

        // glitch rejection
        @(negedge clk);
        rx_bit = 1'b0;
        repeat (20) @(negedge clk);
        rx_bit = 1'b1;
        repeat (300) @(negedge clk);
        rd_check("glitch_status", A_STATUS, 8'h06);

        // framing error
        uart_send(8'h5A, 1'b0);
        repeat (200) @(negedge clk);
        rd_check("framing_status", A_STATUS, 8'h26);
        wb_write(A_STATUS, 8'h20);
        rd_check("framing_clear", A_STATUS, 8'h06);

        // overrun: 17 frames, no reads
        for (int i = 0; i < 17; i++) uart_send(8'h40 + 8'(i), 1'b1);
        rd_check("ovr_status", A_STATUS, 8'h1A);
        for (int i = 0; i < 16; i++) rd_check("ovr_data", A_DATA, 8'h40 + 8'(i));
        rd_check("ovr_drained", A_STATUS, 8'h16);
        wb_write(A_STATUS, 8'h10);
        rd_check("ovr_clear", A_STATUS, 8'h06);

        // reset in the middle of a TX frame
        uart_send(8'h77, 1'b1);
        wb_write(A_DIV_LO, 8'd50);
        wb_write(A_DATA, 8'h00);
        wb_write(A_DATA, 8'h11);
        repeat (300) @(negedge clk);
        check_eq("pre_rst_tx_low", tx_bit, 0);
        #2 reset_n = 1'b0;
        #1;
        check_eq("midrst_tx_bit", tx_bit, 1);
        check_eq("midrst_ack", wb_ack, 0);
        @(negedge clk);
        reset_n = 1'b1;
        rd_check("midrst_status", A_STATUS, 8'h06);
        rd_check("midrst_div_lo", A_DIV_LO, 8'h68);
        repeat (20) @(negedge clk);
        check_eq("midrst_tx_idle", tx_bit, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Overall time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/uart_wb_fifo.md
UART_WB_FIFO -- requirements
Module: uart_wb_fifo

Interface
REQ-001 Parameters SHALL be: CLK_HZ, default 12000000, reference clock frequency in Hz.
REQ-002 Parameters SHALL include: BAUD, default 115200, reset baud rate.
REQ-003 Parameters SHALL include: FIFO_DEPTH, default 16, entries per FIFO, power of two, 2..256.
REQ-004 Port clk SHALL be: input, 1 bit, the single clock for all logic, including the bus.
REQ-005 Port reset_n SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-006 Port wb_addr SHALL be: input, 2 bits, register select.
REQ-007 Port wb_data_in SHALL be: input, 8 bits, write data.
REQ-008 Port wb_data_out SHALL be: output, 8 bits, read data, valid while wb_ack=1.
REQ-009 Port wb_we SHALL be: input, 1 bit, 1=write, 0=read.
REQ-010 Port wb_stb SHALL be: input, 1 bit, strobe/chip select.
REQ-011 Port wb_ack SHALL be: output, 1 bit, one-cycle transfer acknowledge.
REQ-012 Port tx_bit SHALL be: output, 1 bit, UART TX line, idle high.
REQ-013 Port rx_bit SHALL be: input, 1 bit, UART RX line, asynchronous to clk.
REQ-014 Port irq SHALL be: output, 1 bit, interrupt request.

Function
REQ-015 The register map SHALL be as follows.
- Address 0, DATA: a write pushes to the TX FIFO; a read pops the RX FIFO.
- Address 1, STATUS:
  - bit0 tx_full
  - bit1 tx_empty
  - bit2 rx_empty
  - bit3 rx_full
  - bit4 overrun (sticky)
  - bit5 framing (sticky)
  - bit6 tx_busy
  - bit7 0
- Address 2, DIV_LO.
- Address 3, DIV_HI.
REQ-016 Bus transfers SHALL follow these rules.
- wb_ack SHALL pulse high for exactly one cycle, in the cycle after wb_stb is sampled high while wb_ack=0.
- wb_stb held high SHALL yield ack on alternate cycles.
- Each ack is exactly one push or pop.
REQ-017 A write to STATUS SHALL clear each sticky bit whose corresponding wb_data_in bit is 1.
REQ-018 A DATA write when the TX FIFO is full SHALL discard the byte and SHALL leave the FIFO unchanged.
REQ-019 A DATA read when the RX FIFO is empty SHALL return 0x00 and SHALL NOT move the pointers.
REQ-020 The divisor SHALL be the 16-bit value {DIV_HI,DIV_LO} in clk cycles per bit; values below 4 SHALL be treated as 4.
REQ-021 A new divisor SHALL take effect at the next start bit; a frame in progress keeps its old divisor.
REQ-022 The TX FSM SHALL have states IDLE, START, DATA, STOP.
- IDLE->START when the TX FIFO is non-empty; the byte is popped that cycle.
- Data is sent LSB first, 8 bits, followed by 1 stop bit, each lasting divisor cycles.
- STOP->START back-to-back, with no idle gap, if the FIFO is non-empty.
REQ-023 rx_bit SHALL pass through a 2-flop synchroniser.
REQ-024 The RX FSM SHALL have states IDLE, START, DATA, STOP.
- START: the line is resampled at divisor/2; if it is high, return to IDLE (glitch rejected).
- Data bits are sampled at mid-bit.
REQ-025 On a stop bit sampled low, the RX FSM SHALL set framing and drop the byte.
REQ-026 On a valid frame with the RX FIFO full, the RX FSM SHALL set overrun and drop the new byte; FIFO contents SHALL be preserved.
REQ-027 A bus pop and an RX push in the same cycle SHALL both take effect, including when the FIFO is full.
REQ-028 A bus push and a TX pop in the same cycle SHALL both take effect, including when the FIFO is full.
REQ-029 Pointer wrap-around SHALL use a FIFO_DEPTH-entry pointer with an extra wrap bit; full/empty SHALL be exact at depth.

Reset
REQ-030 While reset_n=0, the following SHALL hold.
- Both FIFOs are empty.
- Both FSMs are in IDLE.
- tx_bit=1.
- wb_ack=0.
- wb_data_out=0x00.
- irq=0.
- Sticky bits are 0.
- The divisor is CLK_HZ/BAUD, rounded down.
REQ-031 Reset asserted mid-frame SHALL abort immediately and SHALL drive tx_bit high asynchronously.

Configuration
REQ-032 Macro UART_WB_FIFO_IRQ_EN SHALL control the interrupt logic.
- Defined: irq = (!rx_empty) | tx_empty | overrun | framing, registered with 1-cycle latency.
- Undefined: irq is tied to 0 and no interrupt logic is present.

Structure
REQ-033 Package uart_pkg SHALL hold:
- the register address constants;
- the STATUS bit index constants;
- the TX/RX state enum type.
REQ-034 The sub-module sync_fifo (parameters WIDTH, DEPTH) SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-035 TX frame: divisor 104, write 0xA5 -> tx_bit shows start bit, then 1,0,1,0,0,1,0,1, then stop bit, each 104 cycles; tx_empty=1 after pop.
REQ-036 RX frame: drive 0x3C at 104 cycles/bit -> rx_empty=0; a DATA read returns 0x3C and ack arrives 1 cycle after stb.
REQ-037 RX overrun: FIFO_DEPTH=16, 17 frames with no reads -> rx_full=1, overrun=1, 16 bytes read back in order, 17th byte absent.
REQ-038 RX framing: a frame with its stop bit low -> framing=1 and rx_empty stays 1; a STATUS write of 0x20 clears framing.
REQ-039 Glitch and reset: a 20-cycle low pulse on rx_bit -> no byte, no error; reset_n low mid-TX -> tx_bit=1 that cycle, FIFOs empty.
